// File: rtl/rout_uart_tx_pkg.sv
// Shared definitions for the routa serial transmitter.
// FSM encoding and default bit timing.
package rout_uart_tx_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 4;
  localparam int unsigned WORD_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/rout_fifo.sv
// Word buffer between the routa port and the shifter.
// Full/empty reflect pre-edge occupancy only.
module rout_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT =
    (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR =
    AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy updates; pointers wrap at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ?
        '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ?
        '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/rout_uart_tx.sv
// Serialises 16-bit routa words as two 8N1 bytes,
// high byte first, with a small input FIFO.
module rout_uart_tx
  import rout_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        word_count
);

  localparam logic [7:0] LAST_TICK =
    8'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              hi_sel_q, hi_sel_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [7:0]        wcnt_q, wcnt_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_data;
  logic [7:0]        cur_byte;
  logic              tick;
  logic              tx_bit;

  rout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tick     = (cnt_q == LAST_TICK);
  assign cur_byte = hi_sel_q ?
    shift_q[15:8] : shift_q[7:0];

  assign in_ready   = !fifo_full;
  assign tx         = tx_bit;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign word_count = wcnt_q;

  // Next-state, line level and FIFO pop for the framer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    hi_sel_d  = hi_sel_q;
    shift_d   = shift_q;
    wcnt_d    = wcnt_q;
    fifo_pop  = 1'b0;
    tx_bit    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_data;
          hi_sel_d  = 1'b1;
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (tick) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DATA: begin
        tx_bit = cur_byte[bit_idx_q];
        if (tick) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_STOP: begin
        tx_bit = 1'b1;
        if (tick) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (hi_sel_q) begin
            hi_sel_d = 1'b0;
            state_d  = ST_START;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_data;
              hi_sel_d = 1'b1;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // Framer state; reset abandons any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      hi_sel_q  <= 1'b0;
      shift_q   <= '0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      hi_sel_q  <= hi_sel_d;
      shift_q   <= shift_d;
      wcnt_q    <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_rout_uart_tx.sv
// Bench for rout_uart_tx: frame tables, directed
// corner sequences and a word-level line model.
module tb_rout_uart_tx;

  localparam int C  = 4;
  localparam int D  = 2;
  localparam int C2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic [7:0]  word_count;

  logic        rst2;
  logic [15:0] in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic        tx2;
  logic        busy2;
  logic [7:0]  word_count2;

  always #5 clk = ~clk;

  rout_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .word_count (word_count)
  );

  rout_uart_tx #(
    .CLKS_PER_BIT (C2),
    .FIFO_DEPTH   (D)
  ) dut2 (
    .clk        (clk),
    .reset      (rst2),
    .in_data    (in_data2),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .tx         (tx2),
    .busy       (busy2),
    .word_count (word_count2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h",
               name, act, exp);
    end
  endtask

  // Word-level model: queue of waiting words and the
  // position (in cycles) inside the word on the line.
  logic [15:0] pend[$];
  bit          act;
  int          t;
  logic [15:0] cur;
  int          wc;
  bit          acc_last;

  function automatic logic m_tx();
    int p, w;
    if (!act) return 1'b1;
    p = t / C;
    w = p % 10;
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    if (p < 10) return cur[8 + w - 1];
    return cur[w - 1];
  endfunction

  task automatic m_reset();
    pend.delete();
    act      = 1'b0;
    t        = 0;
    wc       = 0;
    acc_last = 1'b0;
  endtask

  task automatic m_edge();
    acc_last = in_valid && (pend.size() < D);
    if (act && t == 20*C - 1) begin
      wc = (wc + 1) % 256;
      if (pend.size() > 0) begin
        cur = pend.pop_front();
        t   = 0;
      end else begin
        act = 1'b0;
      end
    end else if (act) begin
      t++;
    end else if (pend.size() > 0) begin
      cur = pend.pop_front();
      act = 1'b1;
      t   = 0;
    end
    if (acc_last) pend.push_back(in_data);
  endtask

  task automatic cmp();
    chk("tx", 32'(tx), 32'(m_tx()));
    chk("busy", 32'(busy),
        32'(act || pend.size() > 0));
    chk("in_ready", 32'(in_ready),
        32'(pend.size() < D));
    chk("word_count", 32'(word_count), wc);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) m_edge();
    else acc_last = 1'b0;
    @(negedge clk);
    cmp();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_wc", 32'(word_count), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [0:19] frame;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] words[4];
  int          acc_edge[4];
  int          exp_acc[4];
  int          e, idx, n;
  bit          saw255, any_low;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    rst2      = 1'b1;
    in_valid2 = 1'b0;
    in_data2  = '0;
    m_reset();

    vecs[0] = '{16'hA55A, 20'b0101001011_0010110101};
    vecs[1] = '{16'h0000, 20'b0000000001_0000000001};
    vecs[2] = '{16'hFFFF, 20'b0111111111_0111111111};
    vecs[3] = '{16'h1234, 20'b0010010001_0001011001};

    @(negedge clk);
    do_reset();

    // Single-word frames against hand-derived tables.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      in_data  = vecs[i].data;
      in_valid = 1'b1;
      cyc();
      chk($sformatf("v%0d_lat_idle", i), 32'(tx), 1);
      in_valid = 1'b0;
      cyc();
      chk($sformatf("v%0d_lat_start", i), 32'(tx), 0);
      for (int k = 0; k < 20*C; k++) begin
        if (k % C == C/2)
          chk($sformatf("v%0d_bit%0d", i, k/C),
              32'(tx), 32'(vecs[i].frame[k/C]));
        if (k == 20*C - 1)
          chk($sformatf("v%0d_busy_last", i),
              32'(busy), 1);
        cyc();
      end
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
      chk($sformatf("v%0d_wc", i), 32'(word_count), 1);
    end

    // Held valid with four words: back-pressure.
    do_reset();
    words   = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    exp_acc = '{0, 1, 2, 82};
    acc_edge = '{-1, -1, -1, -1};
    e = 0; idx = 0;
    in_data  = words[0];
    in_valid = 1'b1;
    while (idx < 4 && e < 400) begin
      cyc();
      if (acc_last) begin
        acc_edge[idx] = e;
        idx++;
        if (idx < 4) in_data = words[idx];
        else in_valid = 1'b0;
      end
      e++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("stall_acc%0d", i),
          acc_edge[i], exp_acc[i]);
    while (busy === 1'b1 && e < 1000) begin
      cyc();
      e++;
    end
    chk("stall_edges", e, 322);
    chk("stall_wc", 32'(word_count), 4);

    // Push on the same edge the last entry is popped.
    do_reset();
    in_data  = 16'h1357;
    in_valid = 1'b1;
    cyc();
    in_data = 16'h2468;
    cyc();
    in_valid = 1'b0;
    e = 2;
    while (e < 81) begin
      cyc();
      e++;
    end
    chk("gap_ready_pre", 32'(in_ready), 1);
    in_data  = 16'hC3A5;
    in_valid = 1'b1;
    cyc();
    e++;
    in_valid = 1'b0;
    while (busy === 1'b1 && e < 1000) begin
      cyc();
      e++;
    end
    chk("gap_edges", e, 242);
    chk("gap_wc", 32'(word_count), 3);

    // Reset in the middle of the second byte.
    do_reset();
    in_data  = 16'hA55A;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 51; k++) cyc();
    chk("mid_busy_pre", 32'(busy), 1);
    do_reset();
    any_low = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (tx !== 1'b1) any_low = 1'b1;
    end
    chk("mid_no_bits", 32'(any_low), 0);
    chk("mid_wc", 32'(word_count), 0);

    // 256 zero words: counter wraps to zero.
    do_reset();
    n = 0; e = 0; saw255 = 1'b0;
    in_data  = 16'h0000;
    in_valid = 1'b1;
    while ((n < 256 || act || pend.size() > 0)
           && e < 30000) begin
      cyc();
      e++;
      if (acc_last) n++;
      if (n == 256) in_valid = 1'b0;
      if (word_count == 8'd255) saw255 = 1'b1;
    end
    chk("wrap_words", n, 256);
    chk("wrap_saw255", 32'(saw255), 1);
    chk("wrap_wc", 32'(word_count), 0);
    chk("wrap_busy", 32'(busy), 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (!in_valid) begin
        in_data = 16'($urandom);
        if ($urandom_range(0, 3) == 0)
          in_valid = 1'b1;
      end
      cyc();
      if (acc_last) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        if ($urandom_range(0, 1) == 0)
          in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    e = 0;
    while ((act || pend.size() > 0) && e < 2000) begin
      cyc();
      e++;
    end
    chk("rand_drain_busy", 32'(busy), 0);

    // CLKS_PER_BIT=2 instance, all-ones word.
    rst2 = 1'b0;
    in_data2  = 16'hFFFF;
    in_valid2 = 1'b1;
    chk("c2_ready", 32'(in_ready2), 1);
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("c2_lat_idle", 32'(tx2), 1);
    @(negedge clk);
    for (int k = 0; k < 45; k++) begin
      chk($sformatf("c2_tx%0d", k), 32'(tx2),
          (k == 0 || k == 1 || k == 20 || k == 21)
            ? 0 : 1);
      chk($sformatf("c2_busy%0d", k), 32'(busy2),
          (k < 40) ? 1 : 0);
      @(negedge clk);
    end
    chk("c2_wc", 32'(word_count2), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/rout_uart_tx.md
ROUT_UART_TX -- requirements
Module: rout_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit period (legal range 2..255).
REQ-002 Parameter FIFO_DEPTH, default 2, number of 16-bit words buffered ahead of the shifter (power of two).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  16  result word from the processor output port (routa).
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 tx  output  1  serial line, 8N1 framing, idle high.
REQ-009 busy  output  1  high while any word is buffered or being shifted.
REQ-010 word_count  output  8  number of fully transmitted words, modulo 256.

Function
REQ-011 Word accepted on a rising edge where in_valid && in_ready; in_ready = FIFO not full; in_data ignored when in_valid low.
REQ-012 Upstream holds in_valid/in_data stable until accepted; a word is never dropped or duplicated.
REQ-013 FSM states IDLE, START, DATA, STOP; a byte_sel flag selects high byte (first) or low byte (second) of the current word.
REQ-014 IDLE: tx=1; if FIFO non-empty, pop head into 16-bit shift register, byte_sel=high, go START on the same edge.
REQ-015 Latency: word accepted at edge N into an empty FIFO with FSM IDLE -> tx=0 (start bit) from edge N+1.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-017 DATA: 8 bits of the selected byte, LSB first, each held CLKS_PER_BIT cycles; then STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; then if byte_sel=high, switch to low and go START (no idle gap); else increment word_count and either pop the next word into START (FIFO non-empty) or go IDLE.
REQ-019 One word = 20 bit periods = 20*CLKS_PER_BIT cycles; back-to-back words have no idle gap.
REQ-020 Push and pop in the same cycle are both honoured; in_ready is computed from pre-edge occupancy (no combinational path in_valid -> in_ready).
REQ-021 busy = (state != IDLE) || FIFO non-empty; busy falls in the cycle after the final stop bit ends with FIFO empty.
REQ-022 word_count wraps 255 -> 0 without a flag.
REQ-023 Bit-period counter is 8 bits and resets to 0 at each bit boundary; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-024 reset high forces immediately: state=IDLE, tx=1, FIFO empty, in_ready=1, busy=0, word_count=0, all counters 0.
REQ-025 Reset mid-frame aborts the frame; partial word is discarded and never resumed.
REQ-026 After reset deasserts, the first edge may accept a word.

Structure
REQ-027 Shared package holds FSM state encoding constants (IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT.
REQ-028 One sub-module, rout_fifo (FIFO_DEPTH x 16, push/pop/full/empty), instantiated once; FSM, shifter and counters live in rout_uart_tx.

Verification
REQ-029 Single word 0xA55A, CLKS_PER_BIT=4 -> tx per 4-cycle period: 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1; busy low 80 cycles after start bit; word_count=1.
REQ-030 in_valid held high with 0x0001,0x0002,0x0003,0x0004 -> first three accepted on consecutive edges, fourth stalls (in_ready=0) until first word's shifter empties; four frames back-to-back, 320 cycles, no idle gap.
REQ-031 Reset asserted mid-DATA of second byte -> tx=1, busy=0, in_ready=1 before next edge; no further frame bits; word_count=0.
REQ-032 256 words of 0x0000 -> word_count returns to 0; all frames have correct start/stop bits.
REQ-033 Push on the exact edge the FSM pops the last FIFO entry -> word retained, transmitted next with no gap.
REQ-034 CLKS_PER_BIT=2, word 0xFFFF -> only start bits low; each bit exactly 2 cycles; total 40 cycles.
